writeback_stage_buf: RTL
========================

// Module: writeback_stage_buf
// PURPOSE
//  MEM->WB boundary: a DEPTH-entry elastic buffer with valid/ready handshake, flush and x0-write suppression.
//  Also selects the writeback result (ALU / load data / PC+4).
//  Sits between the memory stage and the register-file write port.
//  Lets the write port (shared or arbitrated) back-pressure MEM without losing instructions.
// PARAMETERS
//  DATA_WIDTH              32  datapath width
//  REG_FILE_ADDRESS_WIDTH  5   register index width
//  DEPTH                   2   buffer entries (>=1); DEPTH>=2 sustains 1 instr/cycle
// PORTS
//  clk         in   1   clock; all state updates on posedge
//  rst         in   1   synchronous, active-high reset
//  ValidM      in   1   MEM stage presents an instruction
//  ReadyM      out  1   buffer can accept this cycle (= !full; no combinational path from WbReadyW)
//  RegWriteM   in   1   instruction writes rd
//  ResultSrcM  in   2   00 ALU, 01 load data, 10 PC+4, 11 reserved (treated as ALU)
//  ALUResultM  in   DATA_WIDTH
//  ReadDataM   in   DATA_WIDTH
//  RdM         in   REG_FILE_ADDRESS_WIDTH
//  PCPlus4M    in   DATA_WIDTH
//  FlushW      in   1   discard all buffered entries and any same-cycle push
//  WbReadyW    in   1   write port accepts the head entry this cycle
//  ValidW      out  1   head entry present (count != 0)
//  RegWriteW   out  1   regfile write enable = ValidW & WbReadyW & head.RegWrite
//  RdW         out  REG_FILE_ADDRESS_WIDTH   head rd; 0 when !ValidW
//  ResultW     out  DATA_WIDTH   selected result of head; 0 when !ValidW
//  PCPlus4W    out  DATA_WIDTH   head PC+4; 0 when !ValidW
// BEHAVIOUR
//  - Push = ValidM & ReadyM & !FlushW. Pop = ValidW & WbReadyW & !FlushW.
//  - The stored RegWrite is RegWriteM & (RdM != 0): x0 is never written and never appears as a writer.
//  - Circular storage: rd_ptr, wr_ptr and count ($clog2(DEPTH+1) bits).
//    Pointers wrap explicitly at DEPTH-1 -> 0, so non-power-of-2 DEPTH is legal.
//  - Latency: a pushed entry is visible at the W outputs the cycle after the push edge. The buffer is FIFO-ordered.
//  - Push and pop in the same cycle: count unchanged, both pointers advance.
//    When full, ReadyM=0, so a pop in that cycle does not admit a push. With DEPTH=1 the peak rate is 1 per 2 cycles.
//  - Empty: ValidW=0, RegWriteW=0, and RdW/ResultW/PCPlus4W are forced to 0.
//  - FlushW: on the next edge count=0 and pointers=0. Same-cycle push and pop are both suppressed,
//    so RegWriteW is 0 during the flush cycle.
//  - rst: identical to flush. After reset ReadyM=1, ValidW=0 and every output is 0. Storage contents are not reset.
//  - rst or FlushW mid-burst: no entry buffered before the edge ever produces RegWriteW.
//  - ResultW is combinational from the head entry; no further register stage.
// CONFIGURATION
//  WB_LOAD_EXT_EN defined:
//    - Adds ports Funct3M[2:0] and ByteOffM[1:0], stored per entry.
//    - For ResultSrc=01, the load data is shifted right by ByteOff*8, then extended per Funct3:
//      000 LB sign, 001 LH sign, 010 LW pass, 100 LBU zero, 101 LHU zero; other codes pass.
//  WB_LOAD_EXT_EN undefined: those ports are absent; ReadDataM is passed through raw.
// STRUCTURE
//  - Package wb_pkg: RESULT_SRC_ALU / RESULT_SRC_MEM / RESULT_SRC_PC4 localparams and
//    F3_LB/F3_LH/F3_LW/F3_LBU/F3_LHU constants.
//  - Sub-module wb_load_ext: purely combinational, instantiated only under WB_LOAD_EXT_EN.
//  - Pointer, count and storage logic stays in this module.
// TESTING
//  1. rst=1 for 2 cycles with ValidM=1 -> ReadyM=1, ValidW=0, RegWriteW=0, ResultW=0 throughout and after release.
//  2. DEPTH=2, WbReadyW=1, back-to-back pushes rd=1..4, ALU=0x10..0x40 ->
//     RegWriteW each cycle, RdW 1,2,3,4, one cycle after each push.
//  3. WbReadyW=0, push 3 entries -> ReadyM=0 after the 2nd push; the 3rd is held at MEM.
//     Raise WbReadyW -> rd order preserved, no loss.
//  4. Push RegWriteM=1, RdM=0 -> ValidW=1, RegWriteW=0.
//     ResultSrc=10, PCPlus4M=0x104 -> ResultW=0x104.
//  5. Buffer full, FlushW=1 with ValidM=1 -> next cycle ValidW=0, count 0, no RegWriteW.
//     A following push appears normally.
//  6. WB_LOAD_EXT_EN: ReadData=0x8899AABB, Funct3=000, ByteOff=1 -> ResultW=0xFFFFFFAA.
//     Funct3=101, ByteOff=2 -> ResultW=0x00008899.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared constants for the MEM->WB writeback buffer: result-source codes and load funct3 codes.
package wb_pkg;

  localparam logic [1:0] RESULT_SRC_ALU = 2'b00;
  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;
  localparam logic [1:0] RESULT_SRC_PC4 = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_load_ext.sv
// Combinational load-data alignment and extension: shift by byte offset, then sign/zero
// extend per the load funct3.
module wb_load_ext import wb_pkg::*; #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [2:0]            i_funct3,
  input  logic [1:0]            i_byte_off,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [DATA_WIDTH-1:0] w_shifted;

  assign w_shifted = i_data >> {i_byte_off, 3'b000};

  always_comb begin
    o_data = w_shifted;
    case (i_funct3)
      F3_LB:   o_data = {{(DATA_WIDTH-8){w_shifted[7]}}, w_shifted[7:0]};
      F3_LH:   o_data = {{(DATA_WIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
      F3_LW:   o_data = w_shifted;
      F3_LBU:  o_data = {{(DATA_WIDTH-8){1'b0}}, w_shifted[7:0]};
      F3_LHU:  o_data = {{(DATA_WIDTH-16){1'b0}}, w_shifted[15:0]};
      default: o_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/writeback_stage_buf.sv
// MEM->WB elastic buffer with valid/ready handshake, flush, x0-write suppression and result select.
// Optional WB_LOAD_EXT_EN adds per-entry funct3/byte-offset and load alignment/extension.
module writeback_stage_buf import wb_pkg::*; #(
  parameter int unsigned DATA_WIDTH             = 32,
  parameter int unsigned REG_FILE_ADDRESS_WIDTH = 5,
  parameter int unsigned DEPTH                  = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              ValidM,
  output logic                              ReadyM,
  input  logic                              RegWriteM,
  input  logic [1:0]                        ResultSrcM,
  input  logic [DATA_WIDTH-1:0]             ALUResultM,
  input  logic [DATA_WIDTH-1:0]             ReadDataM,
  input  logic [REG_FILE_ADDRESS_WIDTH-1:0] RdM,
  input  logic [DATA_WIDTH-1:0]             PCPlus4M,
`ifdef WB_LOAD_EXT_EN
  input  logic [2:0]                        Funct3M,
  input  logic [1:0]                        ByteOffM,
`endif
  input  logic                              FlushW,
  input  logic                              WbReadyW,
  output logic                              ValidW,
  output logic                              RegWriteW,
  output logic [REG_FILE_ADDRESS_WIDTH-1:0] RdW,
  output logic [DATA_WIDTH-1:0]             ResultW,
  output logic [DATA_WIDTH-1:0]             PCPlus4W
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic                              reg_write;
    logic [1:0]                        result_src;
    logic [DATA_WIDTH-1:0]             alu_result;
    logic [DATA_WIDTH-1:0]             read_data;
    logic [REG_FILE_ADDRESS_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]             pc_plus4;
`ifdef WB_LOAD_EXT_EN
    logic [2:0]                        funct3;
    logic [1:0]                        byte_off;
`endif
  } entry_t;

  entry_t               r_mem [DEPTH];
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [CNT_W-1:0]     r_count;

  logic                 w_kill;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  entry_t               w_entry;
  entry_t               w_head;
  logic [DATA_WIDTH-1:0] w_load_data;
  logic [DATA_WIDTH-1:0] w_result;

  // Explicit wrap keeps non-power-of-two depths legal.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign w_kill  = rst | FlushW;
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = ValidM & ~w_full & ~w_kill;
  assign w_pop   = ~w_empty & WbReadyW & ~w_kill;

  always_comb begin
    w_entry            = '0;
    w_entry.reg_write  = RegWriteM & (RdM != '0);
    w_entry.result_src = ResultSrcM;
    w_entry.alu_result = ALUResultM;
    w_entry.read_data  = ReadDataM;
    w_entry.rd         = RdM;
    w_entry.pc_plus4   = PCPlus4M;
`ifdef WB_LOAD_EXT_EN
    w_entry.funct3     = Funct3M;
    w_entry.byte_off   = ByteOffM;
`endif
  end

  always_ff @(posedge clk) begin
    if (w_kill) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is deliberately left unreset; only the occupancy state is cleared.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  assign w_head = r_mem[r_rd_ptr];

`ifdef WB_LOAD_EXT_EN
  wb_load_ext #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_load_ext (
    .i_data     (w_head.read_data),
    .i_funct3   (w_head.funct3),
    .i_byte_off (w_head.byte_off),
    .o_data     (w_load_data)
  );
`else
  assign w_load_data = w_head.read_data;
`endif

  always_comb begin
    w_result = w_head.alu_result;
    case (w_head.result_src)
      RESULT_SRC_MEM: w_result = w_load_data;
      RESULT_SRC_PC4: w_result = w_head.pc_plus4;
      default:        w_result = w_head.alu_result;
    endcase
  end

  assign ReadyM    = ~w_full;
  assign ValidW    = ~w_empty;
  // A flushing or resetting cycle must never commit a stale head entry.
  assign RegWriteW = ValidW & WbReadyW & w_head.reg_write & ~w_kill;
  assign RdW       = ValidW ? w_head.rd       : '0;
  assign ResultW   = ValidW ? w_result        : '0;
  assign PCPlus4W  = ValidW ? w_head.pc_plus4 : '0;

endmodule
